// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit unsigned subtractor, LSB first, start/busy/done handshake
module serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D,
    output logic         Bo
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  xs;
    logic [N-1:0]  ys;
    logic [N-1:0]  rs;
    logic          b;
    logic [CW-1:0] count;

    logic          d;
    logic          b_next;
    logic [N-1:0]  rs_next;

    // One full-subtractor slice on the current LSBs
    assign d       = xs[0] ^ ys[0] ^ b;
    assign b_next  = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b);
    assign rs_next = {d, rs[N-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            xs    <= '0;
            ys    <= '0;
            rs    <= '0;
            b     <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            D     <= '0;
            Bo    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        xs    <= X;
                        ys    <= Y;
                        rs    <= '0;
                        b     <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    xs    <= xs >> 1;
                    ys    <= ys >> 1;
                    rs    <= rs_next;
                    b     <= b_next;
                    count <= count + 1'b1;
                    // Last bit: publish the completed result on this same edge
                    if (count == CW'(N - 1)) begin
                        D     <= rs_next;
                        Bo    <= b_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (N=4 and N=8)
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] x;
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic [3:0] d;
    logic       bo;

    logic       start8;
    logic [7:0] x8;
    logic [7:0] y8;
    logic       busy8;
    logic       done8;
    logic [7:0] d8;
    logic       bo8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.N(4)) dut (
        .clk(clk), .rst(rst), .start(start), .X(x), .Y(y),
        .busy(busy), .done(done), .D(d), .Bo(bo)
    );

    serial_subtractor #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .X(x8), .Y(y8),
        .busy(busy8), .done(done8), .D(d8), .Bo(bo8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one start pulse, then wait for done; returns at the falling edge inside the done cycle.
    task automatic do_op(input logic [3:0] xv, input logic [3:0] yv,
                         output int bcnt, output bit got_done);
        @(negedge clk);
        start = 1'b1; x = xv; y = yv;
        @(negedge clk);
        start = 1'b0;
        bcnt = 0;
        got_done = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            if (done) got_done = 1'b1;
            else begin
                if (busy) bcnt++;
                @(negedge clk);
            end
        end
    endtask

    int bcnt;
    bit got_done;
    int ndone;
    int wait_cycles;

    initial begin
        rst = 1'b1; start = 1'b0; x = '0; y = '0;
        start8 = 1'b0; x8 = '0; y8 = '0;
        #12;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_d", 32'(d), 0);
        check("reset_bo", 32'(bo), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic 9-4
        do_op(4'd9, 4'd4, bcnt, got_done);
        check("9m4_done", 32'(got_done), 1);
        check("9m4_busy_cycles", 32'(bcnt), 4);
        check("9m4_busy_with_done", 32'(busy), 0);
        check("9m4_d", 32'(d), 5);
        check("9m4_bo", 32'(bo), 0);
        @(negedge clk);
        check("9m4_done_one_cycle", 32'(done), 0);

        // Directed vectors incl. boundaries
        do_op(4'd4, 4'd9, bcnt, got_done);
        check("4m9_d", 32'(d), 11);
        check("4m9_bo", 32'(bo), 1);
        do_op(4'd0, 4'd15, bcnt, got_done);
        check("0m15_d", 32'(d), 1);
        check("0m15_bo", 32'(bo), 1);
        do_op(4'd15, 4'd15, bcnt, got_done);
        check("15m15_d", 32'(d), 0);
        check("15m15_bo", 32'(bo), 0);
        do_op(4'd0, 4'd0, bcnt, got_done);
        check("0m0_d", 32'(d), 0);
        check("0m0_bo", 32'(bo), 0);

        // Exhaustive sweep against (x - y) mod 16 and x < y
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_op(4'(i), 4'(j), bcnt, got_done);
                check($sformatf("sweep_d_%0d_%0d", i, j), 32'(d), 32'((i - j + 16) % 16));
                check($sformatf("sweep_bo_%0d_%0d", i, j), 32'(bo), (i < j) ? 1 : 0);
            end
        end

        // Start pulsed during RUN must be ignored
        @(negedge clk);
        start = 1'b1; x = 4'd9; y = 4'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; x = 4'd1; y = 4'd2;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                ndone++;
                check("ignore_d", 32'(d), 5);
                check("ignore_bo", 32'(bo), 0);
            end
            @(negedge clk);
        end
        check("ignore_one_done", 32'(ndone), 1);
        check("ignore_hold_d", 32'(d), 5);
        check("ignore_busy_idle", 32'(busy), 0);

        // Back-to-back with start held high
        start = 1'b1; x = 4'd7; y = 4'd3;
        @(negedge clk);
        x = 4'd3; y = 4'd7;
        got_done = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            if (done) got_done = 1'b1;
            else @(negedge clk);
        end
        check("b2b_first_done", 32'(got_done), 1);
        check("b2b_first_d", 32'(d), 4);
        check("b2b_first_bo", 32'(bo), 0);
        wait_cycles = 0;
        got_done = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            @(negedge clk);
            wait_cycles++;
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        check("b2b_second_latency", 32'(wait_cycles), 5);
        check("b2b_second_d", 32'(d), 12);
        check("b2b_second_bo", 32'(bo), 1);
        @(negedge clk);
        @(negedge clk);
        check("b2b_back_to_idle", 32'(busy), 0);

        // Asynchronous reset mid-RUN
        start = 1'b1; x = 4'd9; y = 4'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_d", 32'(d), 0);
        check("arst_bo", 32'(bo), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("arst_no_done", 32'(ndone), 0);
        do_op(4'd6, 4'd6, bcnt, got_done);
        check("after_rst_done", 32'(got_done), 1);
        check("after_rst_busy_cycles", 32'(bcnt), 4);
        check("after_rst_d", 32'(d), 0);
        check("after_rst_bo", 32'(bo), 0);

        // N=8 instance
        @(negedge clk);
        start8 = 1'b1; x8 = 8'd200; y8 = 8'd55;
        @(negedge clk);
        start8 = 1'b0;
        bcnt = 0;
        got_done = 1'b0;
        for (int i = 0; i < 30 && !got_done; i++) begin
            if (done8) got_done = 1'b1;
            else begin
                if (busy8) bcnt++;
                @(negedge clk);
            end
        end
        check("n8_done", 32'(got_done), 1);
        check("n8_busy_cycles", 32'(bcnt), 8);
        check("n8_d", 32'(d8), 145);
        check("n8_bo", 32'(bo8), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
